// File: rtl/blink_pkg.sv
// blink_pkg: shared channel FSM state type and the SOS default pattern.
package blink_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} blink_state_e;
  localparam logic [34:0] SOS_PATTERN = 35'b10101000_11101110111000_10101000;
endpackage

// File: rtl/blink_prescaler.sv
// blink_prescaler: free-running step prescaler emitting a one-cycle tick every TICK_CYCLES clocks.
module blink_prescaler #(
  parameter int TICK_CYCLES = 2097152
) (
  input  logic CLK,
  input  logic RST_N,
  output logic tick
);
  localparam int W = $clog2(TICK_CYCLES);
  localparam logic [W-1:0] LAST = W'(TICK_CYCLES - 1);
  logic [W-1:0] cnt;
  assign tick = cnt == LAST;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/pattern_blinker.sv
// pattern_blinker: independent multi-channel pattern players stepped by a shared prescaler tick.
module pattern_blinker
  import blink_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int PAT_LEN = 35,
  parameter int TICK_CYCLES = 2097152,
  parameter logic [PAT_LEN-1:0] DEFAULT_PATTERN = PAT_LEN'(SOS_PATTERN),
  localparam int LEN_W = $clog2(PAT_LEN + 1),
  localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [CHANNELS-1:0] start,
  input  logic [CHANNELS-1:0] stop,
  input  logic [CHANNELS-1:0] repeat_mode,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [CH_W-1:0]     load_chan,
  input  logic [PAT_LEN-1:0]  load_pattern,
  input  logic [LEN_W-1:0]    load_len,
  output logic [CHANNELS-1:0] blink_out,
  output logic [CHANNELS-1:0] frame,
  output logic [CHANNELS-1:0] done
);
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(PAT_LEN);
  logic                tick;
  logic [CHANNELS-1:0] run_vec;
  logic [LEN_W-1:0]    len_clamped;
  blink_prescaler #(.TICK_CYCLES(TICK_CYCLES)) u_prescaler (
    .CLK  (CLK),
    .RST_N(RST_N),
    .tick (tick)
  );
  assign len_clamped = (load_len == '0 || load_len > FULL_LEN) ? FULL_LEN : load_len;
  // Out-of-range channels never match, so their loads are accepted and dropped.
  always_comb begin
    load_ready = 1'b1;
    for (int c = 0; c < CHANNELS; c++)
      if (load_chan == CH_W'(c)) load_ready = !run_vec[c];
  end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    blink_state_e       state_q, state_d;
    logic [LEN_W-1:0]   idx_q, idx_d, len_q;
    logic [PAT_LEN-1:0] pat_q, shifted;
    logic               rpt_q, rpt_d, load_hit;
    assign load_hit = load_valid && load_ready && load_chan == CH_W'(i);
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        state_q <= IDLE;
        idx_q   <= '0;
        rpt_q   <= 1'b0;
        pat_q   <= DEFAULT_PATTERN;
        len_q   <= FULL_LEN;
      end else begin
        state_q <= state_d;
        idx_q   <= idx_d;
        rpt_q   <= rpt_d;
        if (load_hit) begin
          pat_q <= load_pattern;
          len_q <= len_clamped;
        end
      end
    end
    always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rpt_d   = rpt_q;
      if (stop[i]) begin
        state_d = IDLE;
        idx_d   = '0;
      end else if (start[i]) begin
        state_d = RUN;
        idx_d   = '0;
        rpt_d   = repeat_mode[i];
      end else if (state_q == RUN && tick) begin
        if (idx_q + LEN_W'(1) == len_q) begin
          idx_d   = '0;
          state_d = rpt_q ? RUN : DONE;
        end else begin
          idx_d = idx_q + LEN_W'(1);
        end
      end
    end
    assign shifted      = pat_q >> idx_q;
    assign run_vec[i]   = state_q == RUN;
    assign blink_out[i] = run_vec[i] && shifted[0];
    assign frame[i]     = run_vec[i] && idx_q == '0;
    assign done[i]      = state_q == DONE;
  end
endmodule
